// File: rtl/dmem_pkg.sv
// Shared constants and helpers for the data-memory responder.
// Holds the MMIO timer map, STATUS bit layout and default depth.
package dmem_pkg;

    localparam int DEPTH_WORDS_DEF = 1024;

    localparam logic [31:0] MMIO_COUNT   = 32'hFFFF_FFF0;
    localparam logic [31:0] MMIO_COMPARE = 32'hFFFF_FFF4;
    localparam logic [31:0] MMIO_STATUS  = 32'hFFFF_FFF8;

    localparam int ST_MATCH = 0;
    localparam int ST_IEN   = 1;

    typedef enum logic [1:0] {
        TREG_COUNT   = 2'd0,
        TREG_COMPARE = 2'd1,
        TREG_STATUS  = 2'd2,
        TREG_NONE    = 2'd3
    } treg_e;

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  wen
    );
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (wen[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Core data-port bus between the load/store unit and the data memory.
// master = core side, slave = memory responder side.
interface dmem_responder_if;
    logic [31:0] dm_addr;
    logic [3:0]  dm_wen;
    logic [31:0] dm_wdata;
    logic        dm_ce_n;
    logic        dm_oe_n;
    logic        dm_we_n;
    logic [31:0] dm_rdata;

    modport master (
        output dm_addr, dm_wen, dm_wdata,
        output dm_ce_n, dm_oe_n, dm_we_n,
        input  dm_rdata
    );

    modport slave (
        input  dm_addr, dm_wen, dm_wdata,
        input  dm_ce_n, dm_oe_n, dm_we_n,
        output dm_rdata
    );
endinterface

// File: rtl/dmem_timer.sv
// Free-running COUNT/COMPARE timer with sticky match and irq enable.
// Only instantiated when DMEM_MMIO_TIMER_EN is defined.
module dmem_timer
    import dmem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr,
    input  treg_e       sel,
    input  logic [3:0]  wen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        match_q, match_d;
    logic        ien_q, ien_d;
    logic [31:0] status;

    always_comb begin
        count_d   = count_q + 32'd1;
        compare_d = compare_q;
        match_d   = match_q;
        ien_d     = ien_q;
        if (wr) begin
            unique case (sel)
                TREG_COUNT:   count_d = merge_bytes(count_q, wdata, wen);
                TREG_COMPARE: compare_d = merge_bytes(compare_q, wdata, wen);
                TREG_STATUS: begin
                    if (wen[0]) begin
                        if (wdata[ST_MATCH]) match_d = 1'b0;
                        ien_d = wdata[ST_IEN];
                    end
                end
                default: ;
            endcase
        end
        // set is applied last so it beats a same-cycle clear
        if (count_q == compare_q && compare_q != 32'd0) match_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            compare_q <= '0;
            match_q   <= 1'b0;
            ien_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            match_q   <= match_d;
            ien_q     <= ien_d;
        end
    end

    always_comb begin
        status           = '0;
        status[ST_MATCH] = match_q;
        status[ST_IEN]   = ien_q;
        unique case (sel)
            TREG_COUNT:   rdata = count_q;
            TREG_COMPARE: rdata = compare_q;
            TREG_STATUS:  rdata = status;
            default:      rdata = '0;
        endcase
    end

    assign irq = match_q & ien_q;

endmodule

// File: rtl/dmem_responder.sv
// Single-port data memory with 1-cycle registered reads and byte writes.
// Optional MMIO timer at the top of the address space: DMEM_MMIO_TIMER_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus,
    output logic             bad_addr,
    output logic             timer_irq,
    input  logic [31:0]      dbg_addr,
    output logic [31:0]      dbg_rdata
);

    logic [31:0]      mem_q [DEPTH_WORDS];
    logic [IDX_W-1:0] idx;
    logic             in_range;
    logic             rd_en, wr_en;
    logic             mmio_hit;
    logic [31:0]      mmio_rdata;
    logic [31:0]      rdata_q, rdata_d;
    logic             bad_q, bad_d;
    logic             unused_bits;

    assign idx      = bus.dm_addr[IDX_W+1:2];
    assign in_range = (bus.dm_addr[31:IDX_W+2] == '0);
    assign rd_en    = !bus.dm_ce_n && !bus.dm_oe_n;
    assign wr_en    = !bus.dm_ce_n && !bus.dm_we_n;

`ifdef DMEM_MMIO_TIMER_EN
    treg_e tsel;

    always_comb begin
        tsel = TREG_NONE;
        if (bus.dm_addr[31:4] == MMIO_COUNT[31:4]) begin
            tsel = treg_e'(bus.dm_addr[3:2]);
        end
    end

    assign mmio_hit = (tsel != TREG_NONE);

    dmem_timer u_timer (
        .clk   (clk),
        .rst   (rst),
        .wr    (wr_en && mmio_hit),
        .sel   (tsel),
        .wen   (bus.dm_wen),
        .wdata (bus.dm_wdata),
        .rdata (mmio_rdata),
        .irq   (timer_irq)
    );
`else
    assign mmio_hit   = 1'b0;
    assign mmio_rdata = '0;
    assign timer_irq  = 1'b0;
`endif

    always_comb begin
        rdata_d = rdata_q;
        bad_d   = bad_q;
        if (rd_en) begin
            if (in_range)      rdata_d = mem_q[idx];
            else if (mmio_hit) rdata_d = mmio_rdata;
            else               rdata_d = '0;
        end
        if ((rd_en || wr_en) && !in_range && !mmio_hit) bad_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
            bad_q   <= 1'b0;
        end else begin
            rdata_q <= rdata_d;
            bad_q   <= bad_d;
        end
    end

    // Storage has no reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (!rst && wr_en && in_range) begin
            mem_q[idx] <= merge_bytes(mem_q[idx], bus.dm_wdata, bus.dm_wen);
        end
    end

    assign bus.dm_rdata = rdata_q;
    assign bad_addr     = bad_q;
    assign dbg_rdata    = mem_q[dbg_addr[IDX_W+1:2]];

    assign unused_bits = ^{dbg_addr[31:IDX_W+2], dbg_addr[1:0],
                           bus.dm_addr[1:0]};

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a per-cycle reference model.
// Timer scenario is compiled in when DMEM_MMIO_TIMER_EN is defined.
module tb_dmem_responder;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        bad_addr;
    logic        timer_irq;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_rdata;

    always #5 clk = ~clk;

    dmem_responder_if bus ();

    dmem_responder #(.DEPTH_WORDS(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .bad_addr  (bad_addr),
        .timer_irq (timer_irq),
        .dbg_addr  (dbg_addr),
        .dbg_rdata (dbg_rdata)
    );

    int checks = 0;
    int errors = 0;
    bit started = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lane_merge(input logic [31:0] o,
                                               input logic [31:0] n,
                                               input logic [3:0] w);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (w[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    // Reference model state
    logic [31:0] mm [int];
    logic [31:0] exp_rdata;
    bit          exp_known;
    bit          exp_bad;
    bit          exp_irq;
    logic [31:0] t_count, t_cmp, n_count, n_cmp;
    bit          t_match, t_ien, n_match, n_ien;

    initial begin : model
        bit          rd, wr, inr, hit;
        int          word, treg;
        logic [31:0] a;
        forever begin
            @(posedge clk);
            a = bus.dm_addr;
            if (rst) begin
                exp_rdata = 0; exp_known = 1; exp_bad = 0;
                t_count = 0; t_cmp = 0; t_match = 0; t_ien = 0;
            end else begin
                rd   = !bus.dm_ce_n && !bus.dm_oe_n;
                wr   = !bus.dm_ce_n && !bus.dm_we_n;
                word = int'(a / 4);
                inr  = (longint'(a) < longint'(DEPTH) * 4);
                hit  = 0;
                treg = -1;
`ifdef DMEM_MMIO_TIMER_EN
                if (a >= 32'hFFFF_FFF0 && a <= 32'hFFFF_FFFB) begin
                    hit  = 1;
                    treg = int'((a - 32'hFFFF_FFF0) / 4);
                end
`endif
                if (rd) begin
                    exp_known = 1;
                    if (inr) begin
                        if (mm.exists(word)) exp_rdata = mm[word];
                        else exp_known = 0;
                    end else if (hit) begin
                        if (treg == 0)      exp_rdata = t_count;
                        else if (treg == 1) exp_rdata = t_cmp;
                        else exp_rdata = {30'd0, t_ien, t_match};
                    end else begin
                        exp_rdata = 0;
                    end
                end
                if ((rd || wr) && !inr && !hit) exp_bad = 1;
                if (wr && inr) begin
                    mm[word] = lane_merge(mm.exists(word) ? mm[word] : 'x,
                                          bus.dm_wdata, bus.dm_wen);
                end
                n_count = t_count + 1;
                n_cmp = t_cmp; n_match = t_match; n_ien = t_ien;
                if (wr && hit) begin
                    if (treg == 0)
                        n_count = lane_merge(t_count, bus.dm_wdata, bus.dm_wen);
                    else if (treg == 1)
                        n_cmp = lane_merge(t_cmp, bus.dm_wdata, bus.dm_wen);
                    else if (bus.dm_wen[0]) begin
                        if (bus.dm_wdata[0]) n_match = 0;
                        n_ien = bus.dm_wdata[1];
                    end
                end
                if (t_count == t_cmp && t_cmp != 0) n_match = 1;
                t_count = n_count; t_cmp = n_cmp;
                t_match = n_match; t_ien = n_ien;
            end
            exp_irq = t_match && t_ien;
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (started) begin
                if (exp_known) check("rdata", bus.dm_rdata, exp_rdata);
                check("bad_addr", {31'd0, bad_addr}, {31'd0, exp_bad});
                check("timer_irq", {31'd0, timer_irq}, {31'd0, exp_irq});
                if (mm.exists(int'(dbg_addr / 4)))
                    check("dbg_rdata", dbg_rdata, mm[int'(dbg_addr / 4)]);
            end
        end
    end

    task automatic idle_bus();
        bus.dm_ce_n = 1; bus.dm_oe_n = 1; bus.dm_we_n = 1; bus.dm_wen = 0;
    endtask

    task automatic op(input logic [31:0] a, input logic [3:0] w,
                      input logic [31:0] d, input bit r, input bit wr_);
        bus.dm_addr = a; bus.dm_wen = w; bus.dm_wdata = d;
        bus.dm_ce_n = 0; bus.dm_oe_n = !r; bus.dm_we_n = !wr_;
        @(negedge clk);
        idle_bus();
    endtask

    initial begin : stim
        int n;
        rst = 1; dbg_addr = 32'h40;
        bus.dm_addr = 0; bus.dm_wdata = 0;
        idle_bus();
        @(negedge clk); @(negedge clk);
        started = 1;
        check("reset_rdata", bus.dm_rdata, 32'h0);
        check("reset_bad", {31'd0, bad_addr}, 32'h0);
        check("reset_irq", {31'd0, timer_irq}, 32'h0);
        rst = 0;

        op(32'h40, 4'hF, 32'h1234_5678, 0, 1);
        op(32'h40, 4'h0, 32'h0, 1, 0);
        check("s1_beat1", bus.dm_rdata, 32'h1234_5678);
        op(32'h40, 4'h0, 32'h0, 1, 0);
        check("s1_beat2", bus.dm_rdata, 32'h1234_5678);
        @(negedge clk);
        check("s1_hold", bus.dm_rdata, 32'h1234_5678);

        op(32'h40, 4'b0010, 32'h0000_AB00, 0, 1);
        op(32'h41, 4'h0, 32'h0, 1, 0);
        check("s2_lane", bus.dm_rdata, 32'h1234_AB78);

        op(32'h80, 4'hF, 32'h0, 0, 1);
        op(32'h80, 4'hF, 32'hDEAD_BEEF, 1, 1);
        check("s3_readfirst", bus.dm_rdata, 32'h0);
        op(32'h80, 4'h0, 32'h0, 1, 0);
        check("s3_after", bus.dm_rdata, 32'hDEAD_BEEF);

        // chip disabled: everything else on the bus must be ignored
        bus.dm_addr = 32'h40; bus.dm_wen = 4'hF; bus.dm_wdata = 32'h5555_5555;
        bus.dm_ce_n = 1; bus.dm_oe_n = 0; bus.dm_we_n = 0;
        @(negedge clk);
        idle_bus();
        check("ce_hold", bus.dm_rdata, 32'hDEAD_BEEF);
        check("ce_nowrite", dbg_rdata, 32'h1234_AB78);

        op(32'h0, 4'hF, 32'h1111_1111, 0, 1);
        check("s4_bad_before", {31'd0, bad_addr}, 32'h0);
        op(32'h0010_0000, 4'hF, 32'hCAFE_F00D, 0, 1);
        check("s4_bad_set", {31'd0, bad_addr}, 32'h1);
        op(32'h0010_0000, 4'h0, 32'h0, 1, 0);
        check("s4_oor_read", bus.dm_rdata, 32'h0);
        op(32'h0, 4'h0, 32'h0, 1, 0);
        check("s4_alias_intact", bus.dm_rdata, 32'h1111_1111);
        repeat (3) @(negedge clk);
        check("s4_sticky", {31'd0, bad_addr}, 32'h1);

        op(32'h40, 4'h0, 32'h0, 1, 0);
        check("s6_pre", bus.dm_rdata, 32'h1234_AB78);
        rst = 1;
        bus.dm_addr = 32'h40; bus.dm_wen = 4'hF; bus.dm_wdata = 32'hFFFF_FFFF;
        bus.dm_ce_n = 0; bus.dm_oe_n = 0; bus.dm_we_n = 0;
        @(negedge clk);
        idle_bus();
        rst = 0;
        check("s6_rdata_clr", bus.dm_rdata, 32'h0);
        check("s6_bad_clr", {31'd0, bad_addr}, 32'h0);
        op(32'h40, 4'h0, 32'h0, 1, 0);
        check("s6_mem40", bus.dm_rdata, 32'h1234_AB78);
        op(32'h80, 4'h0, 32'h0, 1, 0);
        check("s6_mem80", bus.dm_rdata, 32'hDEAD_BEEF);

`ifdef DMEM_MMIO_TIMER_EN
        op(32'hFFFF_FFF4, 4'hF, 32'h20, 0, 1);
        op(32'hFFFF_FFF8, 4'hF, 32'h2, 0, 1);
        op(32'hFFFF_FFF0, 4'hF, 32'h0, 0, 1);
        n = 0;
        while (!timer_irq && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("s5_irq_latency", n, 33);
        op(32'hFFFF_FFF8, 4'hF, 32'h3, 0, 1);
        check("s5_irq_clear", {31'd0, timer_irq}, 32'h0);
        op(32'hFFFF_FFF8, 4'h0, 32'h0, 1, 0);
        check("s5_status", bus.dm_rdata, 32'h2);
        op(32'hFFFF_FFF4, 4'h0, 32'h0, 1, 0);
        check("s5_compare", bus.dm_rdata, 32'h20);
        op(32'hFFFF_FFF0, 4'hF, 32'hFFFF_FFFE, 0, 1);
        op(32'hFFFF_FFF0, 4'h0, 32'h0, 1, 0);
        check("s5_cnt_fffe", bus.dm_rdata, 32'hFFFF_FFFE);
        op(32'hFFFF_FFF0, 4'h0, 32'h0, 1, 0);
        check("s5_cnt_ffff", bus.dm_rdata, 32'hFFFF_FFFF);
        op(32'hFFFF_FFF0, 4'h0, 32'h0, 1, 0);
        check("s5_cnt_wrap", bus.dm_rdata, 32'h0);
        check("s5_mmio_not_bad", {31'd0, bad_addr}, 32'h0);
`else
        n = 0;
        op(32'hFFFF_FFF0, 4'h0, 32'h0, 1, 0);
        check("nommio_read", bus.dm_rdata, 32'h0);
        check("nommio_bad", {31'd0, bad_addr}, 32'h1);
        repeat (40) begin
            @(negedge clk);
            if (timer_irq) n++;
        end
        check("nommio_irq", n, 0);
`endif

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, SHALL set the number of 32-bit data words (power of two, 256..16384).
REQ-002 Parameter IDX_W, default $clog2(DEPTH_WORDS), SHALL set the word-index width.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 dm_addr  input  32  byte address from the core data port.
REQ-006 dm_wen  input  4  byte-lane write enables; lane i is bits [8i+7:8i].
REQ-007 dm_wdata  input  32  store data, already lane-aligned.
REQ-008 dm_ce_n  input  1  chip enable, active-low.
REQ-009 dm_oe_n  input  1  read enable, active-low.
REQ-010 dm_we_n  input  1  write enable, active-low.
REQ-011 dm_rdata  output  32  registered read data.
REQ-012 bad_addr  output  1  sticky out-of-range access flag.
REQ-013 timer_irq  output  1  timer match interrupt, level.
REQ-014 dbg_addr  input  32  display-port byte address.
REQ-015 dbg_rdata  output  32  combinational word at dbg_addr[IDX_W+1:2]; no side effects.

Function
REQ-016 Word index SHALL be dm_addr[IDX_W+1:2]; dm_addr[1:0] SHALL be ignored, and lane selection SHALL come only from dm_wen.
REQ-017 An address SHALL be in range iff dm_addr[31:IDX_W+2] == 0.
REQ-018 Write: at an edge with !rst, !dm_ce_n, !dm_we_n and in range, each lane with dm_wen[i]=1 SHALL update that byte; lanes with dm_wen[i]=0 SHALL keep their value; dm_wen=0 SHALL write nothing.
REQ-019 Read: at an edge with !dm_ce_n and !dm_oe_n, dm_rdata SHALL load the addressed word, giving 1-cycle latency; this matches the core's two-beat load.
REQ-020 With no read enabled, dm_rdata SHALL hold its value, so the same address held for two cycles returns stable data.
REQ-021 A read and a write to the same word at the same edge SHALL be read-first: dm_rdata gets the pre-write value.
REQ-022 An out-of-range write SHALL be dropped; an out-of-range read SHALL load 0. Either SHALL set bad_addr, which stays set until rst.
REQ-023 With dm_ce_n=1, dm_oe_n, dm_we_n, dm_wen and dm_addr SHALL be ignored.

Reset
REQ-024 On rst: dm_rdata=0, bad_addr=0, timer_irq=0, and all timer registers 0; memory contents SHALL NOT be cleared.
REQ-025 A write or read presented in the rst cycle SHALL be discarded.

Configuration
REQ-026 Macro DMEM_MMIO_TIMER_EN defined: the timer SHALL be mapped at 0xFFFF_FFF0 (COUNT), 0xFFFF_FFF4 (COMPARE) and 0xFFFF_FFF8 (STATUS); these addresses SHALL NOT set bad_addr.
REQ-027 COUNT SHALL increment by 1 every cycle and wrap 0xFFFF_FFFF -> 0; a write SHALL replace the enabled bytes, and the written value SHALL take precedence over the increment that cycle.
REQ-028 STATUS[0] (match) SHALL set on the cycle after COUNT == COMPARE with COMPARE != 0; writing 1 to STATUS[0] SHALL clear it; set SHALL win over a simultaneous clear.
REQ-029 STATUS[1] (irq enable) SHALL be read/write; timer_irq SHALL equal STATUS[0] & STATUS[1].
REQ-030 MMIO reads SHALL use the same 1-cycle latency; unused STATUS bits SHALL read 0.
REQ-031 Macro undefined: the MMIO addresses SHALL be out of range, and timer_irq SHALL be tied to 0.

Structure
REQ-032 Package dmem_pkg SHALL hold the MMIO address constants, the STATUS bit positions and the default DEPTH_WORDS.
REQ-033 The timer SHALL be a sub-module dmem_timer, instantiated only under DMEM_MMIO_TIMER_EN.

Verification
REQ-034 Scenario 1: write 0x12345678, wen=1111, addr 0x40; then read addr 0x40 -> dm_rdata=0x12345678 one cycle later, and held on the second beat.
REQ-035 Scenario 2: over the 0x12345678 word, write wdata 0x0000AB00 with wen=0010 -> read returns 0x1234AB78.
REQ-036 Scenario 3: read and write 0xDEADBEEF to addr 0x80 (old value 0x0) in the same cycle -> dm_rdata=0x0; the next read returns 0xDEADBEEF.
REQ-037 Scenario 4: write to addr 0x0010_0000 (DEPTH 1024) -> memory unchanged, bad_addr=1; a following read there returns 0; bad_addr stays 1 until rst.
REQ-038 Scenario 5 (TIMER_EN): COMPARE=0x20, STATUS=0x2, COUNT=0 -> timer_irq rises the cycle after COUNT reaches 0x20; writing STATUS=0x3 clears it; COUNT wraps from 0xFFFF_FFFF to 0.
REQ-039 Scenario 6: assert rst during a pending read -> dm_rdata=0 and previously written memory is intact.
